// File: rtl/ro_puf_controller.sv
`default_nettype none
// ============================================================================
// Module      : ro_puf_controller
// Description : Ring-oscillator PUF evaluation controller. A challenge selects
//               two oscillators. After a warm-up period, rising edges of both
//               oscillators are counted over a fixed window. The response bit
//               is 1 when oscillator A produced strictly more edges than B.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_RO        number of ring oscillators attached (>= 2)
//   SETTLE_CYCLES oscillator warm-up cycles before counting (>= 1)
//   WINDOW        counting window in clk cycles (>= 1)
//   CNT_W         edge-counter width (counters saturate, never wrap)
// Ports
//   clk           sole clock, rising-edge
//   rst           synchronous active-high reset
//   start         evaluation request, only sampled while idle
//   challenge     {sel_b, sel_a}, IDX_W bits each
//   ro_out        raw oscillator outputs (asynchronous to clk)
//   ro_en         per-oscillator loop enable
//   busy          evaluation in progress
//   done          one-cycle completion pulse
//   response      PUF response bit, held until the next accepted start
//   err           invalid-challenge flag, qualified by done
//   cnt_a_dbg/cnt_b_dbg  final counter values (only with RO_PUF_DBG_EN)
// Configuration
//   Define RO_PUF_DBG_EN to add the cnt_a_dbg / cnt_b_dbg debug outputs.
// ============================================================================
module ro_puf_controller #(
  parameter int NUM_RO        = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW        = 1024,
  parameter int CNT_W         = 16,
  localparam int IDX_W        = $clog2(NUM_RO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*IDX_W-1:0]   challenge,
  input  logic [NUM_RO-1:0]    ro_out,
  output logic [NUM_RO-1:0]    ro_en,
  output logic                 busy,
  output logic                 done,
  output logic                 response,
  output logic                 err
`ifdef RO_PUF_DBG_EN
  ,
  output logic [CNT_W-1:0]     cnt_a_dbg,
  output logic [CNT_W-1:0]     cnt_b_dbg
`endif
);

  // Timer only ever needs to reach max(SETTLE_CYCLES, WINDOW) - 1.
  localparam int TMR_MAX = (SETTLE_CYCLES > WINDOW) ? SETTLE_CYCLES : WINDOW;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [IDX_W:0]    NUM_RO_V    = (IDX_W + 1)'(NUM_RO);
  localparam logic [NUM_RO-1:0] RO_ONE      = NUM_RO'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COUNT   = 2'd2,
    ST_COMPARE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [IDX_W-1:0]   sel_a_q, sel_a_d;
  logic [IDX_W-1:0]   sel_b_q, sel_b_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
  logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               response_q, response_d;
  logic               err_q, err_d;
`ifdef RO_PUF_DBG_EN
  logic [CNT_W-1:0]   dbg_a_q, dbg_a_d;
  logic [CNT_W-1:0]   dbg_b_q, dbg_b_d;
`endif

  // Oscillator sampling: bit 0 follows sel_a, bit 1 follows sel_b.
  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic [1:0] hist_q;
  logic [1:0] w_ro_sel;
  logic [1:0] w_rise;

  logic [IDX_W-1:0] w_sel_a;
  logic [IDX_W-1:0] w_sel_b;
  logic             w_chal_ok;

  assign w_sel_a   = challenge[IDX_W-1:0];
  assign w_sel_b   = challenge[2*IDX_W-1:IDX_W];
  assign w_chal_ok = (w_sel_a != w_sel_b) &&
                     ({1'b0, w_sel_a} < NUM_RO_V) &&
                     ({1'b0, w_sel_b} < NUM_RO_V);

  // The mux selects come from registered indices that are stable for the
  // whole evaluation, so muxing the raw async inputs ahead of the first
  // synchronizer flop does not add a new crossing.
  assign w_ro_sel = {ro_out[sel_b_q], ro_out[sel_a_q]};
  assign w_rise   = sync_q & ~hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      meta_q <= w_ro_sel;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    done_d     = 1'b0;
    response_d = response_q;
    err_d      = err_q;
`ifdef RO_PUF_DBG_EN
    dbg_a_d    = dbg_a_q;
    dbg_b_d    = dbg_b_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          response_d = 1'b0;
          err_d      = 1'b0;
`ifdef RO_PUF_DBG_EN
          dbg_a_d    = '0;
          dbg_b_d    = '0;
`endif
          if (w_chal_ok) begin
            sel_a_d = w_sel_a;
            sel_b_d = w_sel_b;
            cnt_a_d = '0;
            cnt_b_d = '0;
            tmr_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            // Rejected challenge: report immediately, oscillators stay off.
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = ST_COUNT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_COUNT: begin
        if (w_rise[0] && (cnt_a_q != CNT_MAX)) begin
          cnt_a_d = cnt_a_q + 1'b1;
        end
        if (w_rise[1] && (cnt_b_q != CNT_MAX)) begin
          cnt_b_d = cnt_b_q + 1'b1;
        end
        if (tmr_q == WINDOW_LAST) begin
          tmr_d   = '0;
          state_d = ST_COMPARE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_COMPARE: begin
        // Strict comparison: a tie resolves to 0.
        response_d = (cnt_a_q > cnt_b_q);
        err_d      = 1'b0;
        done_d     = 1'b1;
`ifdef RO_PUF_DBG_EN
        dbg_a_d    = cnt_a_q;
        dbg_b_d    = cnt_b_q;
`endif
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    if ((state_d == ST_SETTLE) || (state_d == ST_COUNT)) begin
      ro_en_d = (RO_ONE << sel_a_d) | (RO_ONE << sel_b_d);
    end else begin
      ro_en_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      ro_en_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef RO_PUF_DBG_EN
      dbg_a_q    <= '0;
      dbg_b_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      ro_en_q    <= ro_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      response_q <= response_d;
      err_q      <= err_d;
`ifdef RO_PUF_DBG_EN
      dbg_a_q    <= dbg_a_d;
      dbg_b_q    <= dbg_b_d;
`endif
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign err      = err_q;
`ifdef RO_PUF_DBG_EN
  assign cnt_a_dbg = dbg_a_q;
  assign cnt_b_dbg = dbg_b_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_puf_controller
// Description : Scoreboard bench for ro_puf_controller with behavioural ring
//               oscillators. Main instance uses CNT_W=8; a second instance
//               with CNT_W=4 exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_puf_controller;

  localparam int SETTLE = 4;
  localparam int WIN    = 64;
  localparam int LAT    = SETTLE + WIN + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start_s;
  logic [3:0] challenge, challenge_s;
  logic [3:0] ro   = '0;
  logic [3:0] ro_s = '0;
  logic [3:0] ro_en, ro_en_s;
  logic       busy, done, response, err;
  logic       busy_s, done_s, response_s, err_s;
`ifdef RO_PUF_DBG_EN
  logic [7:0] dbg_a, dbg_b;
  logic [3:0] dbg_a_s, dbg_b_s;
`endif

  ro_puf_controller #(.NUM_RO(4), .SETTLE_CYCLES(SETTLE), .WINDOW(WIN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_out(ro),
    .ro_en(ro_en), .busy(busy), .done(done), .response(response), .err(err)
`ifdef RO_PUF_DBG_EN
    , .cnt_a_dbg(dbg_a), .cnt_b_dbg(dbg_b)
`endif
  );

  ro_puf_controller #(.NUM_RO(4), .SETTLE_CYCLES(SETTLE), .WINDOW(WIN), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .challenge(challenge_s), .ro_out(ro_s),
    .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .response(response_s), .err(err_s)
`ifdef RO_PUF_DBG_EN
    , .cnt_a_dbg(dbg_a_s), .cnt_b_dbg(dbg_b_s)
`endif
  );

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        resp;
    logic        err;
    int unsigned at;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_s_q[$];
  exp_t me, me_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Behavioural oscillators: half-periods in clk cycles, held low while
  // disabled so that simultaneously enabled rings run in phase.
  int half_m[4] = '{3, 4, 5, 5};
  int half_s[4] = '{2, 3, 5, 5};
  int rc_m[4]   = '{0, 0, 0, 0};
  int rc_s[4]   = '{0, 0, 0, 0};

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (!ro_en[i]) begin
        ro[i] = 1'b0; rc_m[i] = 0;
      end else begin
        rc_m[i]++;
        if (rc_m[i] == half_m[i]) begin ro[i] = ~ro[i]; rc_m[i] = 0; end
      end
      if (!ro_en_s[i]) begin
        ro_s[i] = 1'b0; rc_s[i] = 0;
      end else begin
        rc_s[i]++;
        if (rc_s[i] == half_s[i]) begin ro_s[i] = ~ro_s[i]; rc_s[i] = 0; end
      end
    end
  end

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (edge %0d)", edge_n);
      end else begin
        me = exp_q.pop_front();
        chk("response", 32'(response), 32'(me.resp));
        chk("err", 32'(err), 32'(me.err));
        chk("done_edge", edge_n, me.at);
        chk("busy_at_done", 32'(busy), 0);
        chk("ro_en_at_done", 32'(ro_en), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done_s === 1'b1) begin
      if (exp_s_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done_sat: got done=1 expected no done (edge %0d)", edge_n);
      end else begin
        me_s = exp_s_q.pop_front();
        chk("sat_response", 32'(response_s), 32'(me_s.resp));
        chk("sat_err", 32'(err_s), 32'(me_s.err));
        chk("sat_done_edge", edge_n, me_s.at);
      end
    end
  end

  // Called at a negedge (cycle 0); returns at the next negedge (cycle 1).
  task automatic issue(input int sa, input int sb, input logic r, input logic e, input bit track);
    exp_t x;
    challenge = {2'(sb), 2'(sa)};
    start     = 1'b1;
    if (track) begin
      x.resp = r;
      x.err  = e;
      x.at   = edge_n + (e ? 1 : LAT);
      exp_q.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    exp_t xs;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; challenge = '0; challenge_s = '0;
    repeat (3) @(negedge clk);
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_response", 32'(response), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sat_ro_en", 32'(ro_en_s), 0);
    rst = 1'b0;
    @(negedge clk);

    // RO0 (period 6) vs RO1 (period 8); challenge swapped after acceptance.
    issue(0, 1, 1'b1, 1'b0, 1'b1);
    challenge = {2'd0, 2'd1};
    @(negedge clk);
    chk("pair_ro_en", 32'(ro_en), 32'h3);
    chk("pair_busy", 32'(busy), 1);
    repeat (68) @(negedge clk);
    // This is the done cycle of the previous run: start must be accepted.
    issue(1, 0, 1'b0, 1'b0, 1'b1);
    repeat (71) @(negedge clk);

    issue(2, 3, 1'b0, 1'b0, 1'b1);     // identical rings: tie -> 0
    repeat (70) @(negedge clk);
    issue(3, 2, 1'b0, 1'b0, 1'b1);
    repeat (70) @(negedge clk);
    issue(0, 2, 1'b1, 1'b0, 1'b1);     // period 6 vs 10
    repeat (72) @(negedge clk);
    chk("response_held", 32'(response), 1);

    // Invalid challenge: immediate done with err, rings never enabled.
    issue(2, 2, 1'b0, 1'b1, 1'b1);
    chk("inv_ro_en_c1", 32'(ro_en), 0);
    chk("inv_busy_c1", 32'(busy), 0);
    @(negedge clk);
    chk("inv_ro_en_c2", 32'(ro_en), 0);
    chk("inv_busy_c2", 32'(busy), 0);
    chk("inv_response_held", 32'(response), 0);
    @(negedge clk);

    // Abort by reset in cycle 30: no done may follow.
    issue(0, 1, 1'b0, 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ro_en", 32'(ro_en), 0);
    chk("abort_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    issue(0, 1, 1'b1, 1'b0, 1'b1);
    repeat (71) @(negedge clk);

    // start held through the whole busy period: one evaluation only.
    issue(1, 0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    repeat (69) @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);

    // Saturation: period-4 ring gives 16 edges into a 4-bit counter.
    challenge_s = {2'd1, 2'd0};
    start_s     = 1'b1;
    xs.resp = 1'b1; xs.err = 1'b0; xs.at = edge_n + LAT;
    exp_s_q.push_back(xs);
    @(negedge clk);
    start_s = 1'b0;
    repeat (75) @(negedge clk);

    for (int k = 0; k < 200 && (exp_q.size() + exp_s_q.size()) != 0; k++) @(negedge clk);
    chk("queues_drained", 32'(exp_q.size() + exp_s_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ro_puf_controller.md
RO_PUF_CONTROLLER -- requirements
Module: ro_puf_controller

Interface
REQ-001 The block SHALL have parameter NUM_RO, default 16: number of ring oscillators attached (minimum 2).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 16: oscillator warm-up cycles before counting (minimum 1).
REQ-003 The block SHALL have parameter WINDOW, default 1024: counting window in clk cycles (minimum 1).
REQ-004 The block SHALL have parameter CNT_W, default 16: edge-counter width.
REQ-005 The block SHALL use IDX_W = clog2(NUM_RO) as a derived width.
REQ-006 Port clk, input, 1: sole clock; all logic rising-edge triggered.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port start, input, 1: request one challenge evaluation; sampled only in IDLE.
REQ-009 Port challenge, input, 2*IDX_W: [IDX_W-1:0] = sel_a, [2*IDX_W-1:IDX_W] = sel_b.
REQ-010 Port ro_out, input, NUM_RO: raw oscillator outputs, asynchronous to clk.
REQ-011 Port ro_en, output, NUM_RO: per-oscillator enable (loop-closing gate).
REQ-012 Port busy, output, 1: high from the cycle after start acceptance through COMPARE.
REQ-013 Port done, output, 1: single-cycle completion pulse.
REQ-014 Port response, output, 1: PUF response bit, held until the next accepted start.
REQ-015 Port err, output, 1: invalid challenge flag, qualified by done.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, COUNT and COMPARE.
REQ-017 In IDLE with start=1 the block SHALL capture sel_a/sel_b, clear both counters and enter SETTLE (valid challenge) next cycle.
REQ-018 A challenge SHALL be invalid when sel_a==sel_b or either index >= NUM_RO; on start with an invalid challenge the block SHALL stay in IDLE, never assert ro_en, and pulse done with err=1, response=0 on the next cycle.
REQ-019 In SETTLE and COUNT, ro_en SHALL be one-hot-pair: bits sel_a and sel_b high, all others low; ro_en SHALL be all-zero in IDLE and COMPARE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles with counters held at 0; COUNT SHALL last exactly WINDOW cycles.
REQ-021 The selected ro_out bits SHALL each pass through a 2-flop synchronizer plus one history flop; a rising edge is synced=1 and history=0.
REQ-022 In COUNT each detected rising edge SHALL increment its counter (cnt_a or cnt_b), saturating at 2^CNT_W-1 with no wrap.
REQ-023 COMPARE SHALL last 1 cycle and register response = (cnt_a > cnt_b); a tie SHALL yield response=0; err=0.
REQ-024 With start sampled at cycle 0 (valid), done SHALL be high at cycle SETTLE_CYCLES+WINDOW+2, with busy low and state IDLE in that same cycle.
REQ-025 start while busy=1 SHALL be ignored; start in the done cycle SHALL be accepted.
REQ-026 Changes on challenge after acceptance SHALL NOT affect the evaluation in progress.
REQ-027 Oscillator frequency SHALL be below clk/2 for exact counting; the block SHALL NOT detect violations.

Reset
REQ-028 On rst=1 at a clk edge the block SHALL enter IDLE and clear ro_en, busy, done, response, err, counters and synchronizer flops to 0, aborting any evaluation in progress.
REQ-029 rst SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro RO_PUF_DBG_EN defined: the block SHALL add output ports cnt_a_dbg and cnt_b_dbg (CNT_W each) carrying the final counter values, updated at COMPARE and held until the next accepted start, reset to 0.
REQ-031 Macro RO_PUF_DBG_EN undefined: those ports and their registers SHALL be absent; all other behaviour identical.

Verification (NUM_RO=4, SETTLE_CYCLES=4, WINDOW=64, CNT_W=8, behavioural ROs)
REQ-032 RO0 period 6 clk, RO1 period 8 clk, challenge sel_a=0 sel_b=1, start -> ro_en=4'b0011 during SETTLE/COUNT, done at cycle 70, response=1, err=0 (debug counts ~10/8).
REQ-033 Same ROs, sel_a=1 sel_b=0 -> response=0; equal periods on RO2/RO3 (identical phase) -> tie, response=0.
REQ-034 sel_a=2 sel_b=2 -> done at cycle 1, err=1, response=0, ro_en never nonzero.
REQ-035 rst asserted at cycle 30 of an evaluation -> next cycle ro_en=0, busy=0, done never pulses; new start afterwards completes normally.
REQ-036 start repeated every cycle during busy -> exactly one done per evaluation; CNT_W=4 with RO period 4 -> counter saturates at 15, no wrap.
